// File: rtl/imem_arbiter_pkg.sv
// Shared constants, state encodings and types for the
// instruction-memory arbiter (fetch port vs. program loader).
`ifndef IMEM_ARBITER_DEFS
`define IMEM_ARBITER_DEFS
`define WORD 32
`define INSTR_LEN 32
`define STATE_IDLE 1'b0
`define STATE_RESP 1'b1
`define ADDR_LSB 2
`endif

package imem_arbiter_pkg;

  localparam int WORD_W  = `WORD;
  localparam int INSTR_W = `INSTR_LEN;
  // Byte-offset bits that must be zero for a word access.
  localparam int LSB_W   = `ADDR_LSB;

  typedef enum logic {
    ST_IDLE = `STATE_IDLE,
    ST_RESP = `STATE_RESP
  } state_e;

  function automatic logic is_aligned(
    input logic [WORD_W-1:0] a
  );
    return a[LSB_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the arbiter.
// slave = arbiter side, master = CPU/loader/memory side.
interface imem_arbiter_if
  import imem_arbiter_pkg::*;
#(
  parameter int AW = 10
);

  logic               fetch_req;
  logic [WORD_W-1:0]  fetch_addr;
  logic               fetch_ready;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_fault;

  logic               load_req;
  logic [WORD_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               load_err;

  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    input  load_req, load_addr, load_data,
    input  mem_rdata,
    output fetch_ready, fetch_valid,
    output fetch_instr, fetch_fault,
    output load_ready, load_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr,
    output load_req, load_addr, load_data,
    output mem_rdata,
    input  fetch_ready, fetch_valid,
    input  fetch_instr, fetch_fault,
    input  load_ready, load_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_addr_check.sv
// Byte address -> word index, plus legality
// (word aligned and inside the memory).
module imem_addr_check
  import imem_arbiter_pkg::*;
#(
  parameter int SIZE = 1024,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic [WORD_W-1:0] addr_i,
  output logic              legal_o,
  output logic [AW-1:0]     index_o
);

  logic [WORD_W-1:0] word_idx;

  // Full-width word number so out-of-range
  // high bits are never silently truncated.
  assign word_idx = {
    LSB_W'(0),
    addr_i[WORD_W-1:LSB_W]
  };

  assign legal_o = is_aligned(addr_i)
                && (word_idx < WORD_W'(SIZE));

  assign index_o = addr_i[AW+LSB_W-1:LSB_W];

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates one instruction memory between CPU fetch
// and the program loader, with anti-starvation for fetch.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int SIZE         = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = $clog2(SIZE)
) (
  input logic           clk,
  input logic           reset,
  imem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic               f_legal;
  logic               l_legal;
  logic [AW-1:0]      f_idx;
  logic [AW-1:0]      l_idx;

  logic               starved;
  logic               f_win;
  logic               f_gnt;
  logic               l_gnt;
  logic               f_rd;
  logic               l_wr;
  logic               resp_live;

  state_e             state_q;
  logic               fault_q;
  logic               lerr_q;
  logic [SW-1:0]      starve_q;
  logic [SW-1:0]      starve_d;
  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      addr_d;
  logic [INSTR_W-1:0] wdata_q;
  logic [INSTR_W-1:0] wdata_d;

  imem_addr_check #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_fetch_chk (
    .addr_i  (bus.fetch_addr),
    .legal_o (f_legal),
    .index_o (f_idx)
  );

  imem_addr_check #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_load_chk (
    .addr_i  (bus.load_addr),
    .legal_o (l_legal),
    .index_o (l_idx)
  );

  // Loader wins unless fetch has waited STARVE_LIMIT grants.
  assign starved = starve_q == SW'(STARVE_LIMIT);
  assign f_win   = bus.fetch_req
                && (!bus.load_req || starved);
  assign f_gnt   = !reset && f_win;
  assign l_gnt   = !reset && bus.load_req && !f_win;

  // Illegal addresses are granted but never reach memory.
  assign f_rd = f_gnt && f_legal;
  assign l_wr = l_gnt && l_legal;

  assign bus.fetch_ready = f_gnt;
  assign bus.load_ready  = l_gnt;

  assign bus.mem_en    = f_rd || l_wr;
  assign bus.mem_we    = l_wr;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;

  // Address/data buses hold their last driven value when idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (f_rd) begin
      addr_d = f_idx;
    end else if (l_wr) begin
      addr_d  = l_idx;
      wdata_d = bus.load_data;
    end
  end

  // Count loader grants that overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (!bus.fetch_req || f_gnt) begin
      starve_d = '0;
    end else if (l_gnt && !starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Response is suppressed while reset is high so a read
  // in flight at reset never surfaces.
  assign resp_live = (state_q == ST_RESP) && !reset;

  assign bus.fetch_valid = resp_live;
  assign bus.fetch_fault = resp_live && fault_q;
  assign bus.fetch_instr =
    (resp_live && !fault_q) ? bus.mem_rdata : '0;
  assign bus.load_err    = lerr_q && !reset;

  // Response-stage FSM plus arbitration bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fault_q  <= 1'b0;
      lerr_q   <= 1'b0;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (f_gnt) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!f_gnt) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      fault_q  <= f_gnt && !f_legal;
      lerr_q   <= l_gnt && !l_legal;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter SIZE, default 1024, is the instruction memory depth in words.
REQ-002 Parameter STARVE_LIMIT, default 4, is the maximum number of consecutive load grants allowed while a fetch waits.
REQ-003 Parameter AW, default $clog2(SIZE), is the memory index width.
REQ-004 One clock; reset is synchronous and active-high (ports clk, reset).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 fetch_req  in  1  CPU fetch request.
REQ-008 fetch_addr  in  `WORD  byte address from PC.
REQ-009 fetch_ready  out  1  fetch accepted this cycle.
REQ-010 fetch_valid  out  1  fetch response valid.
REQ-011 fetch_instr  out  `INSTR_LEN  fetched instruction.
REQ-012 fetch_fault  out  1  response is for a misaligned or out-of-range address.
REQ-013 load_req  in  1  program-loader write request.
REQ-014 load_addr  in  `WORD  loader byte address.
REQ-015 load_data  in  `INSTR_LEN  loader write word.
REQ-016 load_ready  out  1  write accepted this cycle.
REQ-017 load_err  out  1  one-cycle pulse: accepted write was dropped due to a bad address.
REQ-018 mem_en  out  1  memory access strobe.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_addr  out  AW  word index.
REQ-021 mem_wdata  out  `INSTR_LEN  memory write data.
REQ-022 mem_rdata  in  `INSTR_LEN  synchronous read data, valid one cycle after a read strobe.

Function
REQ-023 An address is legal iff addr[1:0]==0 and addr/4 < SIZE; the index SHALL be addr[AW+1:2].
REQ-024 Each cycle at most one requester SHALL be granted; a grant is ready==1 while req==1, and the transfer completes in that cycle.
REQ-025 Priority: load wins by default; fetch wins when fetch_req==1 and starve_cnt==STARVE_LIMIT.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each load grant while fetch_req==1, and SHALL clear on a fetch grant or when fetch_req==0.
REQ-027 Legal fetch grant in cycle N: mem_en=1, mem_we=0, mem_addr=index in N; in N+1: fetch_valid=1, fetch_instr=mem_rdata, fetch_fault=0.
REQ-028 Illegal fetch grant in cycle N: mem_en=0; in N+1: fetch_valid=1, fetch_fault=1, fetch_instr=0.
REQ-029 Fetches SHALL be pipelined: a fetch may be granted every cycle, giving a throughput of one response per cycle.
REQ-030 Legal load grant: mem_en=1, mem_we=1, mem_addr=index, mem_wdata=load_data in the same cycle; no response.
REQ-031 Illegal load grant: mem_en=0, and load_err=1 in the following cycle.
REQ-032 Internal state: a registered rd_pending/fault flag pair (response stage) and starve_cnt; states are IDLE (no pending response) and RESP (response due this cycle).
REQ-033 A write granted in cycle N+1 to the index read in cycle N SHALL NOT alter the N+1 response (read-before-write ordering).
REQ-034 With no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.

Reset
REQ-035 While reset==1: fetch_ready=0, load_ready=0, mem_en=0, mem_we=0.
REQ-036 In the cycle after reset==1 is sampled: fetch_valid=0, fetch_fault=0, fetch_instr=0, load_err=0, starve_cnt=0, state IDLE.
REQ-037 A read in flight when reset is asserted SHALL be discarded and produce no response.

Structure
REQ-038 `WORD and `INSTR_LEN SHALL come from the shared constants header; STATE encodings and the address-legality width SHALL be defined there too.
REQ-039 One combinational sub-module, imem_addr_check (addr in -> legal, index out), SHALL be instantiated twice (fetch and load); the memory array itself is external.

Verification
REQ-040 Preload index 3=0xF84003E0; fetch_addr=12 in cycle N -> fetch_valid with fetch_instr=0xF84003E0 in N+1, fetch_fault=0.
REQ-041 fetch_req held with addresses 0,4,8,12 -> four consecutive responses, one per cycle, in order.
REQ-042 fetch_addr=6 -> mem_en=0, then fetch_fault=1 with fetch_instr=0; fetch_addr=4096 (SIZE=1024) -> same result.
REQ-043 load_req and fetch_req both held continuously -> exactly 4 load grants, then 1 fetch grant, repeating.
REQ-044 load_addr=8192 -> no memory write, load_err pulses for one cycle.
REQ-045 Fetch granted in cycle N, reset=1 in N+1 -> fetch_valid stays 0; after reset, all outputs are zero and the first fetch behaves as in REQ-040.
